iob_eth_rx_slot_ctrl: RTL and testbench
=======================================

Name: iob_eth_rx_slot_ctrl

Overview:
Frame-slot controller between the Ethernet MII receiver and a multi-slot RX frame buffer memory.
It reserves a buffer slot when a frame starts and steers receiver byte writes into that slot. At frame end it acknowledges the receiver and queues a descriptor (slot, length, CRC status) for the consumer.
It drops frames when all slots are full, when it is disabled, or on CRC error (configurable). The receiver is never stalled. Everything runs in RX_CLK; CDC to the system clock is done elsewhere.

Parameters:
NSLOTS, 4, number of frame slots; power of 2, >= 2
SLOT_W, 2, log2(NSLOTS)
DROP_CRC_ERR, 1, 1 = frames with CRC error are discarded, 0 = queued with desc_crc_err=1
CNT_W, 16, width of drop counters

Ports:
RX_CLK  in  1  receive clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-high
en  in  1  accept frames; sampled at frame start
rx_data_rcvd  in  1  receiver frame-complete flag; held high until acked
rx_wr  in  1  receiver byte write strobe
rx_addr  in  11  receiver byte address within frame
rx_crc_err  in  1  receiver CRC status, valid while rx_data_rcvd=1
rx_ack  out  1  one-cycle acknowledge to receiver
mem_addr  out  SLOT_W+11  {wr_slot, rx_addr}
mem_wr  out  1  buffer memory write enable
desc_valid  out  1  descriptor queue not empty
desc_slot  out  SLOT_W  slot of head frame
desc_len  out  11  byte count of head frame
desc_crc_err  out  1  CRC flag of head frame
desc_pop  in  1  consumer releases head slot
occupancy  out  SLOT_W+1  queued frames, 0..NSLOTS
drop_full_cnt  out  CNT_W  frames dropped because full or en=0
drop_crc_cnt  out  CNT_W  frames dropped for CRC error

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; wr_ptr=rd_ptr=0; len_cnt=0; drop_cur=0.
- FSM states: IDLE, RECV, ACK, WAIT_CLR.
- IDLE:
  - rx_wr=1 -> RECV. drop_cur <= (occupancy==NSLOTS) | ~en. len_cnt <= rx_addr+1.
  - rx_data_rcvd=1 with no prior rx_wr (empty frame) -> ACK. No descriptor, no counter change.
- mem_wr = rx_wr & ~drop_now, combinational.
  - drop_now = (occupancy==NSLOTS)|~en while in IDLE; drop_cur otherwise.
  - The first byte is therefore gated correctly.
- mem_addr = {wr_ptr, rx_addr}, combinational.
- RECV:
  - Each rx_wr: len_cnt <= rx_addr+1 (11-bit, wraps; no saturation).
  - rx_data_rcvd=1 -> ACK, committing on that edge:
    - drop_cur=1: drop_full_cnt++.
    - else rx_crc_err=1 and DROP_CRC_ERR=1: drop_crc_cnt++.
    - else: write len_cnt and rx_crc_err to descriptor entry wr_ptr; wr_ptr++ (mod NSLOTS); occupancy++.
- ACK: rx_ack=1 for exactly this cycle (registered). -> WAIT_CLR.
- WAIT_CLR: stay while rx_data_rcvd=1; -> IDLE when 0. rx_wr is ignored (mem_wr=0) in ACK and WAIT_CLR.
- Pop: desc_pop & desc_valid -> rd_ptr++ (mod NSLOTS), occupancy--. desc_pop with desc_valid=0 is ignored.
- Simultaneous commit and pop: occupancy unchanged, both pointers advance.
- A pop during RECV frees a slot but does not un-drop the current frame; drop_cur is fixed at frame start.
- Full check happens only at frame start. The slot wr_ptr cannot be the head of a queued descriptor while reception is in progress, so queued frames are never overwritten.
- Head outputs: desc_slot = rd_ptr; desc_len/desc_crc_err = entry[rd_ptr]; desc_valid = (occupancy!=0).
- Drop counters saturate at all-ones.
- en changes mid-frame have no effect on that frame.
- rst mid-frame: frame abandoned, queue emptied, counters cleared; rx_ack not issued.

Test Plan:
- Single frame: en=1, 64 bytes (rx_addr 0..63) then rx_data_rcvd, crc ok -> mem_wr on all 64 writes at mem_addr {0,addr}. One-cycle rx_ack. desc_valid=1, desc_slot=0, desc_len=64, desc_crc_err=0, occupancy=1.
- Fill and overflow, NSLOTS=4: 5 frames, no pops -> occupancy=4. 5th frame: mem_wr=0 throughout, rx_ack still pulsed, drop_full_cnt=1. Slots 0..3 are popped in order.
- CRC drop: frame with rx_crc_err=1 and DROP_CRC_ERR=1 -> no descriptor, drop_crc_cnt=1, wr_ptr unchanged. With DROP_CRC_ERR=0 -> queued with desc_crc_err=1.
- Simultaneous push/pop at occupancy=2 -> occupancy stays 2, wr_ptr and rd_ptr both advance. Wrap: 6 frames with interleaved pops -> slot sequence 0,1,2,3,0,1.
- en=0 at frame start, raised mid-frame -> frame dropped, drop_full_cnt++. Next frame is accepted normally.
- Async rst asserted mid-RECV -> all outputs 0 within the reset. After release, a new frame is stored in slot 0.

Source files
------------

// File: rtl/iob_eth_rx_slot_ctrl_if.sv
// RX slot controller bus: receiver side, buffer write side,
// descriptor queue side and drop statistics.
interface iob_eth_rx_slot_ctrl_if #(
  parameter int SLOT_W = 2,
  parameter int CNT_W  = 16
);
  logic              en;
  logic              rx_data_rcvd;
  logic              rx_wr;
  logic [10:0]       rx_addr;
  logic              rx_crc_err;
  logic              rx_ack;
  logic [SLOT_W+10:0] mem_addr;
  logic              mem_wr;
  logic              desc_valid;
  logic [SLOT_W-1:0] desc_slot;
  logic [10:0]       desc_len;
  logic              desc_crc_err;
  logic              desc_pop;
  logic [SLOT_W:0]   occupancy;
  logic [CNT_W-1:0]  drop_full_cnt;
  logic [CNT_W-1:0]  drop_crc_cnt;

  modport slave (
    input  en, rx_data_rcvd, rx_wr, rx_addr, rx_crc_err, desc_pop,
    output rx_ack, mem_addr, mem_wr, desc_valid, desc_slot,
    output desc_len, desc_crc_err, occupancy,
    output drop_full_cnt, drop_crc_cnt
  );

  modport master (
    output en, rx_data_rcvd, rx_wr, rx_addr, rx_crc_err, desc_pop,
    input  rx_ack, mem_addr, mem_wr, desc_valid, desc_slot,
    input  desc_len, desc_crc_err, occupancy,
    input  drop_full_cnt, drop_crc_cnt
  );
endinterface

// File: rtl/iob_eth_rx_slot_ctrl.sv
// Ethernet RX frame-slot controller: reserves a buffer slot per
// frame, steers receiver writes, and queues frame descriptors.
module iob_eth_rx_slot_ctrl #(
  parameter int NSLOTS       = 4,
  parameter int SLOT_W       = 2,
  parameter int DROP_CRC_ERR = 1,
  parameter int CNT_W        = 16
) (
  input logic RX_CLK,
  input logic rst,
  iob_eth_rx_slot_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    ACK,
    WAIT_CLR
  } state_t;

  localparam logic [SLOT_W:0] FULL = (SLOT_W+1)'(NSLOTS);
  localparam logic CRC_DROP = (DROP_CRC_ERR != 0);

  state_t state, state_nxt;

  logic [SLOT_W-1:0] wr_ptr;
  logic [SLOT_W-1:0] rd_ptr;
  logic [SLOT_W:0]   occ;
  logic [10:0]       len_cnt;
  logic              drop_cur;
  logic              rx_ack;
  logic [CNT_W-1:0]  full_cnt;
  logic [CNT_W-1:0]  crc_cnt;
  logic [10:0]       len_mem [NSLOTS];
  logic [NSLOTS-1:0] crc_mem;

  logic full;
  logic drop_now;
  logic start;
  logic commit;
  logic push;
  logic pop;
  logic crc_drop;

  assign full     = (occ == FULL);
  assign start    = (state == IDLE) & bus.rx_wr;
  assign drop_now = (state == IDLE) ? (full | ~bus.en) : drop_cur;
  assign commit   = (state == RECV) & bus.rx_data_rcvd;
  assign crc_drop = commit & ~drop_cur & bus.rx_crc_err & CRC_DROP;
  assign push     = commit & ~drop_cur & ~crc_drop;
  assign pop      = bus.desc_pop & (occ != '0);

  assign bus.mem_wr = bus.rx_wr & ~drop_now &
                      ((state == IDLE) | (state == RECV));
  assign bus.mem_addr      = {wr_ptr, bus.rx_addr};
  assign bus.rx_ack        = rx_ack;
  assign bus.desc_valid    = (occ != '0);
  assign bus.desc_slot     = rd_ptr;
  assign bus.desc_len      = len_mem[rd_ptr];
  assign bus.desc_crc_err  = crc_mem[rd_ptr];
  assign bus.occupancy     = occ;
  assign bus.drop_full_cnt = full_cnt;
  assign bus.drop_crc_cnt  = crc_cnt;

  // State register; ack is registered and high only in ACK
  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rx_ack <= 1'b0;
    end else begin
      state  <= state_nxt;
      rx_ack <= (state_nxt == ACK);
    end
  end

  // Next-state: empty frame goes straight to ACK from IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.rx_wr)             state_nxt = RECV;
        else if (bus.rx_data_rcvd) state_nxt = ACK;
      end
      RECV: begin
        if (bus.rx_data_rcvd) state_nxt = ACK;
      end
      ACK: state_nxt = WAIT_CLR;
      WAIT_CLR: begin
        if (!bus.rx_data_rcvd) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame tracking: drop decision is frozen at the first byte
  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) begin
      drop_cur <= 1'b0;
      len_cnt  <= '0;
    end else begin
      if (start) drop_cur <= full | ~bus.en;
      if (bus.rx_wr && (state == IDLE || state == RECV))
        len_cnt <= bus.rx_addr + 11'd1;
    end
  end

  // Descriptor queue: pointers, occupancy and entry storage
  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      crc_mem <= '0;
      for (int i = 0; i < NSLOTS; i++) len_mem[i] <= '0;
    end else begin
      if (push) begin
        len_mem[wr_ptr] <= len_cnt;
        crc_mem[wr_ptr] <= bus.rx_crc_err;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Saturating drop statistics
  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) begin
      full_cnt <= '0;
      crc_cnt  <= '0;
    end else begin
      if (commit && drop_cur && full_cnt != '1)
        full_cnt <= full_cnt + 1'b1;
      if (crc_drop && crc_cnt != '1)
        crc_cnt <= crc_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_iob_eth_rx_slot_ctrl.sv
// Directed bench for the RX slot controller with a descriptor
// scoreboard; a second instance keeps CRC-errored frames.
module tb_iob_eth_rx_slot_ctrl;

  localparam int NS = 4;
  localparam int SW = 2;
  localparam int CW = 16;

  logic RX_CLK = 1'b0;
  logic rst;

  always #5 RX_CLK = ~RX_CLK;

  iob_eth_rx_slot_ctrl_if #(.SLOT_W(SW), .CNT_W(CW)) b ();
  iob_eth_rx_slot_ctrl_if #(.SLOT_W(SW), .CNT_W(CW)) b0 ();

  assign b0.en           = b.en;
  assign b0.rx_data_rcvd = b.rx_data_rcvd;
  assign b0.rx_wr        = b.rx_wr;
  assign b0.rx_addr      = b.rx_addr;
  assign b0.rx_crc_err   = b.rx_crc_err;
  assign b0.desc_pop     = b.desc_pop;

  iob_eth_rx_slot_ctrl #(
    .NSLOTS(NS), .SLOT_W(SW), .DROP_CRC_ERR(1), .CNT_W(CW)
  ) dut (
    .RX_CLK(RX_CLK), .rst(rst), .bus(b)
  );

  iob_eth_rx_slot_ctrl #(
    .NSLOTS(NS), .SLOT_W(SW), .DROP_CRC_ERR(0), .CNT_W(CW)
  ) dut_keep (
    .RX_CLK(RX_CLK), .rst(rst), .bus(b0)
  );

  typedef struct packed {
    logic [SW-1:0] slot;
    logic [10:0]   len;
    logic          crc;
  } desc_t;

  desc_t         sq[$];
  logic [SW-1:0] exp_wr;
  int            exp_full;
  int            exp_crc;
  int            checks;
  int            errors;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state();
    chk("occupancy", 64'(b.occupancy), 64'(sq.size()));
    chk("desc_valid", 64'(b.desc_valid), 64'(sq.size() != 0));
    chk("drop_full_cnt", 64'(b.drop_full_cnt), 64'(exp_full));
    chk("drop_crc_cnt", 64'(b.drop_crc_cnt), 64'(exp_crc));
  endtask

  task automatic chk_head();
    chk("head_valid", 64'(b.desc_valid), 64'(1));
    chk("head_slot", 64'(b.desc_slot), 64'(sq[0].slot));
    chk("head_len", 64'(b.desc_len), 64'(sq[0].len));
    chk("head_crc", 64'(b.desc_crc_err), 64'(sq[0].crc));
  endtask

  // One frame of n bytes; en_s at start, en_m from mid-frame on
  task automatic frame(input int n, input logic crc,
                       input logic en_s, input logic en_m,
                       input logic pop_end);
    logic drop;
    int   k;
    drop = (sq.size() == NS) || !en_s;
    b.en = en_s;
    for (int i = 0; i < n; i++) begin
      @(negedge RX_CLK);
      b.rx_wr   = 1'b1;
      b.rx_addr = 11'(i);
      if (i == n / 2 && i != 0) b.en = en_m;
      #1;
      chk("mem_wr", 64'(b.mem_wr), 64'(!drop));
      chk("mem_addr", 64'(b.mem_addr), 64'({exp_wr, 11'(i)}));
    end
    @(negedge RX_CLK);
    b.rx_wr        = 1'b0;
    b.rx_data_rcvd = 1'b1;
    b.rx_crc_err   = crc;
    if (pop_end) begin
      chk_head();
      b.desc_pop = 1'b1;
      void'(sq.pop_front());
    end
    if (n > 0) begin
      if (drop) exp_full++;
      else if (crc) exp_crc++;
      else begin
        sq.push_back('{slot: exp_wr, len: 11'(n), crc: crc});
        exp_wr++;
      end
    end
    k = 0;
    @(negedge RX_CLK);
    b.desc_pop = 1'b0;
    while (!b.rx_ack && k < 8) begin
      @(negedge RX_CLK);
      k++;
    end
    chk("rx_ack_pulse", 64'(b.rx_ack), 64'(1));
    @(negedge RX_CLK);
    chk("rx_ack_one_cycle", 64'(b.rx_ack), 64'(0));
    b.rx_data_rcvd = 1'b0;
    b.rx_crc_err   = 1'b0;
    b.en           = 1'b1;
    @(negedge RX_CLK);
    chk_state();
  endtask

  task automatic pop_head();
    @(negedge RX_CLK);
    chk_head();
    b.desc_pop = 1'b1;
    void'(sq.pop_front());
    @(negedge RX_CLK);
    b.desc_pop = 1'b0;
    chk_state();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks         = 0;
    errors         = 0;
    exp_wr         = '0;
    exp_full       = 0;
    exp_crc        = 0;
    rst            = 1'b1;
    b.en           = 1'b1;
    b.rx_data_rcvd = 1'b0;
    b.rx_wr        = 1'b0;
    b.rx_addr      = '0;
    b.rx_crc_err   = 1'b0;
    b.desc_pop     = 1'b0;
    repeat (3) @(negedge RX_CLK);
    chk("rst_rx_ack", 64'(b.rx_ack), 64'(0));
    chk("rst_mem_wr", 64'(b.mem_wr), 64'(0));
    chk("rst_desc_len", 64'(b.desc_len), 64'(0));
    chk("rst_desc_slot", 64'(b.desc_slot), 64'(0));
    chk_state();
    rst = 1'b0;

    // single 64-byte frame
    frame(64, 1'b0, 1'b1, 1'b1, 1'b0);
    chk_head();
    pop_head();

    // fill four slots, fifth frame dropped as full
    frame(10, 1'b0, 1'b1, 1'b1, 1'b0);
    frame(20, 1'b0, 1'b1, 1'b1, 1'b0);
    frame(30, 1'b0, 1'b1, 1'b1, 1'b0);
    frame(40, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("occ_full", 64'(b.occupancy), 64'(4));
    frame(50, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("full_drop", 64'(b.drop_full_cnt), 64'(1));
    repeat (4) pop_head();

    // CRC error: dropped here, queued by the keeping instance
    frame(16, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("crc_keep_valid", 64'(b0.desc_valid), 64'(1));
    chk("crc_keep_flag", 64'(b0.desc_crc_err), 64'(1));
    chk("crc_keep_len", 64'(b0.desc_len), 64'(16));
    chk("crc_keep_slot", 64'(b0.desc_slot), 64'(exp_wr));
    chk("crc_keep_cnt", 64'(b0.drop_crc_cnt), 64'(0));
    @(negedge RX_CLK);
    b.desc_pop = 1'b1;
    @(negedge RX_CLK);
    b.desc_pop = 1'b0;
    chk("crc_keep_popped", 64'(b0.occupancy), 64'(0));
    chk("pop_empty_ignored", 64'(b.occupancy), 64'(0));
    chk("pop_empty_slot", 64'(b.desc_slot), 64'(exp_wr));

    // simultaneous commit and pop at occupancy 2
    frame(5, 1'b0, 1'b1, 1'b1, 1'b0);
    frame(6, 1'b0, 1'b1, 1'b1, 1'b0);
    frame(7, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("push_pop_occ", 64'(b.occupancy), 64'(2));
    repeat (2) pop_head();

    // wrap with interleaved pops
    for (int f = 0; f < 6; f++) begin
      frame(3 + f, 1'b0, 1'b1, 1'b1, 1'b0);
      pop_head();
    end

    // en low at start, raised mid-frame: still dropped
    frame(12, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("en_drop", 64'(b.drop_full_cnt), 64'(2));
    frame(12, 1'b0, 1'b1, 1'b1, 1'b0);
    pop_head();

    // empty frame: ack only
    frame(0, 1'b0, 1'b1, 1'b1, 1'b0);

    // reset in the middle of a frame with one frame queued
    frame(9, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge RX_CLK);
      b.rx_wr   = 1'b1;
      b.rx_addr = 11'(i);
    end
    #2;
    rst       = 1'b1;
    b.rx_wr   = 1'b0;
    b.rx_addr = '0;
    #1;
    sq.delete();
    exp_wr   = '0;
    exp_full = 0;
    exp_crc  = 0;
    chk("mid_rst_mem_addr", 64'(b.mem_addr), 64'(0));
    chk("mid_rst_mem_wr", 64'(b.mem_wr), 64'(0));
    chk("mid_rst_rx_ack", 64'(b.rx_ack), 64'(0));
    chk("mid_rst_desc_len", 64'(b.desc_len), 64'(0));
    chk("mid_rst_desc_slot", 64'(b.desc_slot), 64'(0));
    chk_state();
    @(negedge RX_CLK);
    chk("rst_no_ack", 64'(b.rx_ack), 64'(0));
    rst = 1'b0;
    frame(20, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("post_rst_slot", 64'(b.desc_slot), 64'(0));
    pop_head();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
